// File: rtl/satalnk_txsched.sv
`default_nettype none
// ============================================================================
// Module   : satalnk_txsched
// Purpose  : Transmit-side link-layer dword scheduler. Arbitrates the single
//            PHY TX dword slot between upstream link traffic, periodic ALIGN
//            pairs and (optionally) CONT compression of repeated primitives.
// Ports    : i_clk, i_reset        - clock, synchronous active-high reset
//            i_valid/o_ready       - upstream dword handshake
//            i_primitive, i_data   - upstream dword and its primitive flag
//            o_valid/i_ready       - PHY dword handshake
//            o_primitive, o_data   - registered output dword
// Options  : SATA_CONT_EN - when defined, repeated primitives are compressed
//            into X X CONT junk junk ... using a Galois LFSR
//            (x^32+x^22+x^2+x+1) for the junk dwords.
// Revision : 1.0 - initial release
// ============================================================================
module satalnk_txsched #(
  parameter logic [32:0] P_CONT           = 33'h17caa9999,
  parameter logic [32:0] P_ALIGN          = 33'h1bc4a4a7b,
  parameter int unsigned P_ALIGN_INTERVAL = 254,
  parameter logic [31:0] P_LFSR_SEED      = 32'hffffffff
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_primitive,
  input  logic [31:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_primitive,
  output logic [31:0] o_data
);

  localparam logic [15:0] c_interval = 16'(P_ALIGN_INTERVAL);

  logic [1:0]  r_align_pending;
  logic [15:0] r_align_cnt;

  logic        w_load_en;
  logic        w_accept;
  logic        w_up_is_align;
  logic [15:0] w_cnt_inc;
  logic        w_interval_hit;
  logic        w_sub_prim;
  logic [31:0] w_sub_data;

  // The output register may take a new dword when empty or being drained.
  assign w_load_en      = !o_valid || i_ready;
  assign o_ready        = w_load_en && (r_align_pending == 2'd0) && !i_reset;
  assign w_accept       = i_valid && o_ready;
  assign w_up_is_align  = ({i_primitive, i_data} == P_ALIGN);
  assign w_cnt_inc      = r_align_cnt + 16'd1;
  assign w_interval_hit = (w_cnt_inc == c_interval);

`ifdef SATA_CONT_EN
  localparam logic [31:0] c_lfsr_taps = 32'h0040_0007;

  logic [1:0]  r_rep_cnt;
  logic        r_cont_active;
  logic [31:0] r_lfsr;
  logic [31:0] r_last_prim;
  logic [31:0] w_lfsr_next;
  logic        w_same_prim;

  assign w_lfsr_next = {r_lfsr[30:0], 1'b0} ^ (r_lfsr[31] ? c_lfsr_taps : 32'h0);
  // A repeat only counts against a primitive loaded since the last
  // data/ALIGN; r_rep_cnt==0 means no primitive is being tracked.
  assign w_same_prim = i_primitive && (r_rep_cnt != 2'd0) && (i_data == r_last_prim);

  always_comb begin
    w_sub_prim = i_primitive;
    w_sub_data = i_data;
    if (w_same_prim) begin
      if (r_cont_active) begin
        w_sub_prim = 1'b0;
        w_sub_data = w_lfsr_next;
      end else if (r_rep_cnt == 2'd2) begin
        w_sub_prim = P_CONT[32];
        w_sub_data = P_CONT[31:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rep_cnt     <= 2'd0;
      r_cont_active <= 1'b0;
      r_lfsr        <= P_LFSR_SEED;
      r_last_prim   <= 32'h0;
    end else if (w_load_en) begin
      // ALIGN ends a CONT run at the receiver, and data breaks repetition.
      if ((r_align_pending != 2'd0) || (w_accept && (w_up_is_align || !i_primitive))) begin
        r_rep_cnt     <= 2'd0;
        r_cont_active <= 1'b0;
      end else if (w_accept) begin
        if (w_same_prim) begin
          if (r_cont_active) begin
            r_lfsr <= w_lfsr_next;
          end else if (r_rep_cnt == 2'd2) begin
            r_cont_active <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + 2'd1;
          end
        end else begin
          r_rep_cnt     <= 2'd1;
          r_cont_active <= 1'b0;
          r_last_prim   <= i_data;
        end
      end
    end
  end
`else
  // Compression disabled: primitives pass through untouched.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{P_CONT, P_LFSR_SEED};
  assign w_sub_prim   = i_primitive;
  assign w_sub_data   = i_data;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid         <= 1'b0;
      o_primitive     <= 1'b0;
      o_data          <= 32'h0;
      r_align_pending <= 2'd2;
      r_align_cnt     <= 16'd0;
    end else if (w_load_en) begin
      if (r_align_pending != 2'd0) begin
        o_valid         <= 1'b1;
        o_primitive     <= P_ALIGN[32];
        o_data          <= P_ALIGN[31:0];
        r_align_pending <= r_align_pending - 2'd1;
      end else if (w_accept) begin
        o_valid <= 1'b1;
        if (w_up_is_align) begin
          // Upstream ALIGN does not advance the spacing counter.
          o_primitive <= P_ALIGN[32];
          o_data      <= P_ALIGN[31:0];
        end else begin
          o_primitive <= w_sub_prim;
          o_data      <= w_sub_data;
          if (w_interval_hit) begin
            r_align_cnt     <= 16'd0;
            r_align_pending <= 2'd2;
          end else begin
            r_align_cnt <= w_cnt_inc;
          end
        end
      end else begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_satalnk_txsched.sv
`default_nettype none
// ============================================================================
// Module   : tb_satalnk_txsched
// Purpose  : Directed self-checking bench for satalnk_txsched. Runs with the
//            ALIGN interval set to 10 so that pairs recur within short
//            streams. Expectations follow SATA_CONT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_satalnk_txsched;

  localparam logic [32:0] c_align = 33'h1bc4a4a7b;
  localparam logic [32:0] c_cont  = 33'h17caa9999;
  localparam logic [32:0] c_hold  = 33'h1d5d5aa7c;
  localparam logic [32:0] c_dat   = 33'h012345678;
  // Successive Galois LFSR states from the all-ones seed.
  localparam logic [32:0] c_j1 = 33'h0ffbffff9;
  localparam logic [32:0] c_j2 = 33'h0ff3ffff5;
  localparam logic [32:0] c_j3 = 33'h0fe3fffed;
  localparam logic [32:0] c_j4 = 33'h0fc3fffdd;
  localparam logic [32:0] c_j5 = 33'h0f83fffbd;
  localparam logic [32:0] c_j6 = 33'h0f03fff7d;
  localparam logic [32:0] c_j7 = 33'h0e03ffefd;
  localparam logic [32:0] c_j8 = 33'h0c03ffdfd;

  logic        clk = 1'b0;
  logic        i_reset, i_valid, i_primitive, i_ready;
  logic [31:0] i_data;
  logic        o_ready, o_valid, o_primitive;
  logic [31:0] o_data;

  int nvec  = 0;
  int nfail = 0;

  logic [32:0] up_q[$];
  logic [32:0] sent_q[$];
  logic [32:0] out_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] rx_q[$];
  logic [32:0] prims[4] = '{33'h1d5d5aa7c, 33'h14a4a7c7c, 33'h1b5b5957c, 33'h1954a4a7c};

  always #5 clk = ~clk;

  satalnk_txsched #(.P_ALIGN_INTERVAL(10)) u_dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_primitive (i_primitive),
    .i_data      (i_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_primitive (o_primitive),
    .o_data      (o_data)
  );

  task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag);
    check({tag, " length"}, 33'(out_q.size()), 33'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s beat %0d", tag, i), out_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_primitive = 1'b0; i_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;
    out_q.delete();
    exp_q.delete();
  endtask

  // Drives up_q upstream, captures every PHY transfer into out_q, and checks
  // that a stalled output word is held stable.
  task automatic run(input int budget, input bit rnd);
    int          cyc = 0;
    bit          done = 1'b0;
    bit          take, stalled;
    logic [32:0] held;
    while (!done) begin
      i_valid = (up_q.size() != 0);
      {i_primitive, i_data} = i_valid ? up_q[0] : 33'h0;
      i_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      #1;
      if (o_valid && i_ready) out_q.push_back({o_primitive, o_data});
      take    = i_valid && o_ready;
      stalled = o_valid && !i_ready;
      held    = {o_primitive, o_data};
      @(posedge clk);
      #1;
      if (take) void'(up_q.pop_front());
      if (stalled) begin
        check("stall valid", {32'h0, o_valid}, 33'h1);
        check("stall data", {o_primitive, o_data}, held);
      end
      cyc++;
      if (up_q.size() == 0 && !o_valid) done = 1'b1;
      else if (cyc >= budget) begin
        check("run timeout", 33'(cyc), 33'(budget + 1));
        done = 1'b1;
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [32:0] w_rx;
  logic [32:0] lastp;
  bit          in_cont;
  int          last, p, r, n;

  initial begin
    // ---- 1: reset state and the post-reset ALIGN pair ----
    i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_primitive = 1'b0; i_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst o_valid", {32'h0, o_valid}, 33'h0);
    check("rst o_ready", {32'h0, o_ready}, 33'h0);
    check("rst o_data", {o_primitive, o_data}, 33'h0);
    i_reset = 1'b0;
    #1;
    check("pre-align o_ready", {32'h0, o_ready}, 33'h0);
    @(posedge clk); #1;
    check("align1 valid", {32'h0, o_valid}, 33'h1);
    check("align1 data", {o_primitive, o_data}, c_align);
    check("align1 o_ready", {32'h0, o_ready}, 33'h0);
    @(posedge clk); #1;
    check("align2 valid", {32'h0, o_valid}, 33'h1);
    check("align2 data", {o_primitive, o_data}, c_align);
    check("align2 o_ready", {32'h0, o_ready}, 33'h1);
    @(posedge clk); #1;
    check("idle valid", {32'h0, o_valid}, 33'h0);

    // ---- 2: data stream with ALIGN pair insertion every 10 dwords ----
    do_reset();
    exp_q.push_back(c_align); exp_q.push_back(c_align);
    for (int i = 0; i < 12; i++) begin
      up_q.push_back({1'b0, 32'hd000_0000 + 32'(i)});
      if (i == 10) begin exp_q.push_back(c_align); exp_q.push_back(c_align); end
      exp_q.push_back({1'b0, 32'hd000_0000 + 32'(i)});
    end
    run(200, 1'b0);
    cmp_q("data stream");

    // ---- 3: repeated primitive then data ----
    do_reset();
    repeat (8) up_q.push_back(c_hold);
    up_q.push_back(c_dat);
    exp_q.push_back(c_align); exp_q.push_back(c_align);
`ifdef SATA_CONT_EN
    exp_q.push_back(c_hold); exp_q.push_back(c_hold); exp_q.push_back(c_cont);
    exp_q.push_back(c_j1); exp_q.push_back(c_j2); exp_q.push_back(c_j3);
    exp_q.push_back(c_j4); exp_q.push_back(c_j5);
`else
    repeat (8) exp_q.push_back(c_hold);
`endif
    exp_q.push_back(c_dat);
    run(200, 1'b0);
    cmp_q("cont run");

    // ---- 4: ALIGN pair lands mid CONT run ----
    do_reset();
    repeat (14) up_q.push_back(c_hold);
    exp_q.push_back(c_align); exp_q.push_back(c_align);
`ifdef SATA_CONT_EN
    exp_q.push_back(c_hold); exp_q.push_back(c_hold); exp_q.push_back(c_cont);
    exp_q.push_back(c_j1); exp_q.push_back(c_j2); exp_q.push_back(c_j3); exp_q.push_back(c_j4);
    exp_q.push_back(c_j5); exp_q.push_back(c_j6); exp_q.push_back(c_j7);
    exp_q.push_back(c_align); exp_q.push_back(c_align);
    exp_q.push_back(c_hold); exp_q.push_back(c_hold); exp_q.push_back(c_cont); exp_q.push_back(c_j8);
`else
    repeat (10) exp_q.push_back(c_hold);
    exp_q.push_back(c_align); exp_q.push_back(c_align);
    repeat (4) exp_q.push_back(c_hold);
`endif
    run(200, 1'b0);
    cmp_q("align in cont");

    // ---- 6: reset while a CONT run is active ----
    do_reset();
    repeat (6) up_q.push_back(c_hold);
    exp_q.push_back(c_align); exp_q.push_back(c_align);
`ifdef SATA_CONT_EN
    exp_q.push_back(c_hold); exp_q.push_back(c_hold); exp_q.push_back(c_cont);
    exp_q.push_back(c_j1); exp_q.push_back(c_j2); exp_q.push_back(c_j3);
`else
    repeat (6) exp_q.push_back(c_hold);
`endif
    run(200, 1'b0);
    cmp_q("pre-reset run");
    i_valid = 1'b1; {i_primitive, i_data} = c_hold; i_ready = 1'b1;
    #1;
    check("mid-run o_ready", {32'h0, o_ready}, 33'h1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("mid-run valid", {32'h0, o_valid}, 33'h1);
`ifdef SATA_CONT_EN
    check("mid-run data", {o_primitive, o_data}, c_j4);
`else
    check("mid-run data", {o_primitive, o_data}, c_hold);
`endif
    i_reset = 1'b1;
    @(posedge clk); #1;
    check("reset o_valid", {32'h0, o_valid}, 33'h0);
    check("reset o_ready", {32'h0, o_ready}, 33'h0);
    check("reset o_data", {o_primitive, o_data}, 33'h0);
    i_reset = 1'b0;
    out_q.delete(); exp_q.delete();
    repeat (4) up_q.push_back(c_hold);
    up_q.push_back(c_dat);
    exp_q.push_back(c_align); exp_q.push_back(c_align);
`ifdef SATA_CONT_EN
    exp_q.push_back(c_hold); exp_q.push_back(c_hold); exp_q.push_back(c_cont); exp_q.push_back(c_j1);
`else
    repeat (4) exp_q.push_back(c_hold);
`endif
    exp_q.push_back(c_dat);
    run(200, 1'b0);
    cmp_q("post-reset run");

    // ---- 5: random backpressure, decoded by a receive-side CONT remover ----
    do_reset();
    last = -1;
    while (up_q.size() < 1000) begin
      p = $urandom_range(0, 3);
      if (p == last) p = (p + 1) % 4;
      last = p;
      r = $urandom_range(1, 6);
      for (int k = 0; k < r; k++) up_q.push_back(prims[p]);
      // Data only follows short runs so it never trails a CONT/junk run.
      if (r <= 2) begin
        n = $urandom_range(0, 3);
        for (int k = 0; k < n; k++) up_q.push_back({1'b0, 32'($urandom())});
        if (n > 0) last = -1;
      end
    end
    sent_q = up_q;
    run(20000, 1'b1);
    in_cont = 1'b0;
    lastp   = 33'h0;
    foreach (out_q[i]) begin
      w_rx = out_q[i];
      if (w_rx == c_align) in_cont = 1'b0;
      else if (w_rx == c_cont) begin
        in_cont = 1'b1;
        rx_q.push_back(lastp);
      end else if (w_rx[32]) begin
        lastp   = w_rx;
        in_cont = 1'b0;
        rx_q.push_back(w_rx);
      end else if (in_cont) rx_q.push_back(lastp);
      else rx_q.push_back(w_rx);
    end
    check("rx length", 33'(rx_q.size()), 33'(sent_q.size()));
    for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
      check($sformatf("rx dword %0d", i), rx_q[i], sent_q[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
